glb_core_pcfg_switch: RTL and testbench

GLB_CORE_PCFG_SWITCH -- requirements
Module: glb_core_pcfg_switch

---
 rtl/glb_core_pcfg_switch.sv | 108 ++++++++++
 tb/tb_glb_core_pcfg_switch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/glb_core_pcfg_switch.sv
// Config-stream switch for a GLB tile: selects the local PC DMA stream or the west stream,
// forwards it east after one stage and to the CGRA after PIPE_DEPTH stages. Optional macro: GLB_PCFG_COLLISION_CHK_EN.
module glb_core_pcfg_switch #(
    parameter int CFG_ADDR_W = 32,
    parameter int CFG_DATA_W = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_pc_dma_mode,
    input  logic                  pc_wr_en,
    input  logic [CFG_ADDR_W-1:0] pc_addr,
    input  logic [CFG_DATA_W-1:0] pc_data,
    input  logic                  w_rd_en,
    input  logic                  w_wr_en,
    input  logic [CFG_ADDR_W-1:0] w_addr,
    input  logic [CFG_DATA_W-1:0] w_data,
    output logic                  e_rd_en,
    output logic                  e_wr_en,
    output logic [CFG_ADDR_W-1:0] e_addr,
    output logic [CFG_DATA_W-1:0] e_data,
    output logic                  cgra_rd_en,
    output logic                  cgra_wr_en,
    output logic [CFG_ADDR_W-1:0] cgra_addr,
    output logic [CFG_DATA_W-1:0] cgra_data,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic                  collision_err
);

    typedef struct packed {
        logic                  rd_en;
        logic                  wr_en;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cfg_t sel;
    cfg_t pipe [PIPE_DEPTH];

    // Idle beats carry zero addr/data so downstream tiles never see stale payloads.
    always_comb begin
        sel = '0;
        if (cfg_pc_dma_mode) begin
            sel.rd_en = 1'b0;
            sel.wr_en = pc_wr_en;
            sel.addr  = pc_addr;
            sel.data  = pc_data;
        end else begin
            sel.rd_en = w_rd_en;
            sel.wr_en = w_wr_en;
            sel.addr  = w_addr;
            sel.data  = w_data;
        end
        if (!sel.rd_en && !sel.wr_en) begin
            sel.addr = '0;
            sel.data = '0;
        end
    end

    // Stage 0 feeds the east tile; the last stage feeds the CGRA columns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= sel;
            for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign e_rd_en    = pipe[0].rd_en;
    assign e_wr_en    = pipe[0].wr_en;
    assign e_addr     = pipe[0].addr;
    assign e_data     = pipe[0].data;
    assign cgra_rd_en = pipe[PIPE_DEPTH-1].rd_en;
    assign cgra_wr_en = pipe[PIPE_DEPTH-1].wr_en;
    assign cgra_addr  = pipe[PIPE_DEPTH-1].addr;
    assign cgra_data  = pipe[PIPE_DEPTH-1].data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
        end else if (cnt_clr) begin
            wr_cnt <= '0;
        end else if (cgra_wr_en && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

`ifdef GLB_PCFG_COLLISION_CHK_EN
    // West traffic arriving while the local DMA owns the stream is lost; flag it until cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_err <= 1'b0;
        end else if (cnt_clr) begin
            collision_err <= 1'b0;
        end else if (cfg_pc_dma_mode && (w_wr_en || w_rd_en)) begin
            collision_err <= 1'b1;
        end
    end
`else
    assign collision_err = 1'b0;
`endif

endmodule

// File: tb/tb_glb_core_pcfg_switch.sv
// Scoreboard bench for glb_core_pcfg_switch: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_glb_core_pcfg_switch;

    localparam int PD = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode, pc_wr_en, w_rd_en, w_wr_en, cnt_clr;
    logic [31:0] pc_addr, pc_data, w_addr, w_data;
    logic        e_rd_en, e_wr_en, cgra_rd_en, cgra_wr_en, collision_err;
    logic [31:0] e_addr, e_data, cgra_addr, cgra_data;
    logic [15:0] wr_cnt;
    logic        e4_rd_en, e4_wr_en, c4_rd_en, c4_wr_en, coll4;
    logic [31:0] e4_addr, e4_data, c4_addr, c4_data;
    logic [3:0]  wr_cnt4;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t eq[$];
    exp_t cq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glb_core_pcfg_switch #(.CFG_ADDR_W(32), .CFG_DATA_W(32), .PIPE_DEPTH(PD), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_pc_dma_mode(mode),
        .pc_wr_en(pc_wr_en), .pc_addr(pc_addr), .pc_data(pc_data),
        .w_rd_en(w_rd_en), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .e_rd_en(e_rd_en), .e_wr_en(e_wr_en), .e_addr(e_addr), .e_data(e_data),
        .cgra_rd_en(cgra_rd_en), .cgra_wr_en(cgra_wr_en), .cgra_addr(cgra_addr), .cgra_data(cgra_data),
        .cnt_clr(cnt_clr), .wr_cnt(wr_cnt), .collision_err(collision_err)
    );

    glb_core_pcfg_switch #(.CFG_ADDR_W(32), .CFG_DATA_W(32), .PIPE_DEPTH(PD), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .cfg_pc_dma_mode(mode),
        .pc_wr_en(pc_wr_en), .pc_addr(pc_addr), .pc_data(pc_data),
        .w_rd_en(w_rd_en), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .e_rd_en(e4_rd_en), .e_wr_en(e4_wr_en), .e_addr(e4_addr), .e_data(e4_data),
        .cgra_rd_en(c4_rd_en), .cgra_wr_en(c4_wr_en), .cgra_addr(c4_addr), .cgra_data(c4_data),
        .cnt_clr(cnt_clr), .wr_cnt(wr_cnt4), .collision_err(coll4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; any valid beat is expected east after 1 edge and at the CGRA after PD edges.
    task automatic drive(input logic m, input logic pw, input logic [31:0] pa, input logic [31:0] pdat,
                         input logic wr_rd, input logic wr_wr, input logic [31:0] wa, input logic [31:0] wd);
        exp_t x;
        mode = m; pc_wr_en = pw; pc_addr = pa; pc_data = pdat;
        w_rd_en = wr_rd; w_wr_en = wr_wr; w_addr = wa; w_data = wd;
        if (m) begin
            x.rd = 1'b0; x.wr = pw; x.addr = pa; x.data = pdat;
        end else begin
            x.rd = wr_rd; x.wr = wr_wr; x.addr = wa; x.data = wd;
        end
        if (x.rd || x.wr) begin
            x.due = cyc + 1;  eq.push_back(x);
            x.due = cyc + PD; cq.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((eq.size() != 0 || cq.size() != 0) && i < 40) begin
            idle(1);
            i++;
        end
        idle(1);
        check("drain_pending", 64'(eq.size() + cq.size()), 64'd0);
    endtask

    task automatic mon(input string side, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, inout exp_t q[$]);
        exp_t x;
        checks++;
        if (rd || wr) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s_unexpected: got rd=%0b wr=%0b addr=0x%0h data=0x%0h at cyc %0d, expected nothing",
                         side, rd, wr, a, d, cyc);
            end else begin
                x = q.pop_front();
                if (rd !== x.rd || wr !== x.wr || a !== x.addr || d !== x.data || cyc != x.due) begin
                    errors++;
                    $display("FAIL %s_beat: got rd=%0b wr=%0b addr=0x%0h data=0x%0h cyc %0d, expected rd=%0b wr=%0b addr=0x%0h data=0x%0h cyc %0d",
                             side, rd, wr, a, d, cyc, x.rd, x.wr, x.addr, x.data, x.due);
                end
            end
        end else if (a !== 32'h0 || d !== 32'h0) begin
            errors++;
            $display("FAIL %s_idle_zero: got addr=0x%0h data=0x%0h, expected 0", side, a, d);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon("east", e_rd_en, e_wr_en, e_addr, e_data, eq);
            mon("cgra", cgra_rd_en, cgra_wr_en, cgra_addr, cgra_data, cq);
        end
    end

    initial begin
        logic exp_coll;
`ifdef GLB_PCFG_COLLISION_CHK_EN
        exp_coll = 1'b1;
`else
        exp_coll = 1'b0;
`endif
        reset = 1'b1; cnt_clr = 1'b0;
        mode = 1'b0; pc_wr_en = 1'b0; pc_addr = '0; pc_data = '0;
        w_rd_en = 1'b0; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_east", {e_rd_en, e_wr_en, e_addr, e_data}, 64'h0);
        check("rst_cgra", {cgra_rd_en, cgra_wr_en, cgra_addr, cgra_data}, 64'h0);
        check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check("rst_collision", 64'(collision_err), 64'd0);
        reset = 1'b0;
        idle(2);

        // 4-word PC burst
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h10 + i, 32'hA0 + i, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        check("burst_wr_cnt", 64'(wr_cnt), 64'd4);

        // West read passes through, does not count
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h55, 32'h77);
        check("rd_east_now", {e_rd_en, e_wr_en, e_addr}, {32'h0, 1'b1, 1'b0, 32'h55});
        idle(1);
        check("rd_cgra_now", {cgra_rd_en, cgra_wr_en, cgra_addr}, {32'h0, 1'b1, 1'b0, 32'h55});
        drain();
        check("rd_wr_cnt", 64'(wr_cnt), 64'd4);

        // West write during DMA mode is dropped
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99, 32'h1234);
        check("coll_next", 64'(collision_err), 64'(exp_coll));
        idle(1);
        check("coll_sticky", 64'(collision_err), 64'(exp_coll));
        drain();
        check("coll_wr_cnt", 64'(wr_cnt), 64'd4);
        cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
        check("coll_cleared", 64'(collision_err), 64'd0);
        check("clr_wr_cnt", 64'(wr_cnt), 64'd0);

        // Mode toggle with a PC word in flight
        drive(1'b1, 1'b1, 32'h30, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hD0);
        drive(1'b0, 1'b1, 32'h31, 32'hC1, 1'b0, 1'b1, 32'h41, 32'hD1);
        drain();
        check("toggle_wr_cnt", 64'(wr_cnt), 64'd3);

        // Saturation on the 4-bit counter, then clear against a concurrent write
        cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        check("sat_wr_cnt4", 64'(wr_cnt4), 64'd15);
        check("sat_wr_cnt16", 64'(wr_cnt), 64'd20);
        drive(1'b1, 1'b1, 32'h300, 32'h301, 1'b0, 1'b0, 32'h0, 32'h0);
        if (PD > 1) idle(PD - 1);
        check("clr_cgra_wr_live", 64'(cgra_wr_en), 64'd1);
        cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
        check("clr_over_inc4", 64'(wr_cnt4), 64'd0);
        check("clr_over_inc16", 64'(wr_cnt), 64'd0);
        drain();

        // Reset mid-burst with two words in flight
        drive(1'b1, 1'b1, 32'h60, 32'hE0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 32'h61, 32'hE1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #1;
        check("midrst_east", {e_rd_en, e_wr_en, e_addr, e_data}, 64'h0);
        check("midrst_cgra", {cgra_rd_en, cgra_wr_en, cgra_addr, cgra_data}, 64'h0);
        check("midrst_wr_cnt", 64'(wr_cnt), 64'd0);
        eq.delete(); cq.delete();
        mode = 1'b0; pc_wr_en = 1'b0; pc_addr = '0; pc_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(6);
        check("postrst_wr_cnt", 64'(wr_cnt), 64'd0);
        check("postrst_collision", 64'(collision_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
